ep1_report_arbiter: RTL and testbench
=====================================

Name: ep1_report_arbiter

Overview:
Shares the EP1 interrupt-IN packet buffer between two HID report sources: requester 0 is the live keyboard scanner and requester 1 is the macro player. On each EP1 IN-transaction completion it selects one pending requester and copies that requester's report into the EP1 buffer. It then raises ep1tx so the USB core sends the packet. It sits between the report producers and the ULPI/USB endpoint logic, and replaces per-source direct writes to the EP1 buffer.

Parameters:
REPORT_LEN, 8, bytes copied per report (1..64).
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = fixed priority, requester 0 wins.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
req  in  2  per-requester level: a report is ready. Held until ack.
gnt  out  2  one-hot; high for the whole fill while that requester owns rd_addr.
ack  out  2  one-cycle pulse: the granted report has been committed to EP1.
rd_addr  out  6  byte index into the granted requester's report.
rd_data0  in  8  requester 0 byte. Valid one clk after rd_addr (synchronous ROM/RAM).
rd_data1  in  8  requester 1 byte, same timing.
ep1txd  in  1  toggles once per EP1 IN transaction serviced (data or NAK); clk domain.
ep1tx  out  1  level: EP1 buffer holds a report to send.
ep1wraddr  out  6  EP1 buffer write address.
ep1wrdata  out  8  EP1 buffer write data.
ep1wr  out  1  EP1 buffer write strobe, one cycle per byte.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async) values:
  - ep1tx=0, ep1wr=0, ep1wraddr=0, ep1wrdata=0, rd_addr=0, gnt=0, ack=0, busy=0.
  - last_grant=1, so requester 0 wins the first contention.
  - state=IDLE, tog_pend=0.
  - txd_old is loaded from ep1txd on the first clk after release. No toggle is detected on that cycle.
- Toggle detection:
  - Every cycle, ep1txd != txd_old sets tog_pend=1 and updates txd_old.
  - A toggle arriving in any state is recorded. Multiple toggles during one fill collapse to a single pending event.
- IDLE:
  - If tog_pend=1 and req != 0: clear tog_pend, drop ep1tx to 0, choose the winner, set gnt, go to FILL.
  - If tog_pend=1 and req == 0: clear tog_pend, set ep1tx=0 (endpoint NAKs), stay in IDLE.
  - If tog_pend=0: hold all outputs.
- Arbitration:
  - A single request wins.
  - On contention with ROUND_ROBIN=1, the requester != last_grant wins.
  - On contention with ROUND_ROBIN=0, requester 0 wins.
  - last_grant updates on every grant.
- FILL, pipelined with one-cycle read latency:
  - Cycle k (0..REPORT_LEN-1) drives rd_addr=k.
  - Cycle k+1 writes ep1wraddr=k, ep1wrdata=rd_dataN, ep1wr=1.
  - REPORT_LEN writes occur over REPORT_LEN+1 cycles. ep1wr=0 outside write cycles.
  - req falling during FILL is ignored; the fill completes.
- COMMIT, one cycle after the last write:
  - ep1tx=1, ack[winner]=1 for one cycle, gnt=0, rd_addr=0.
  - Return to IDLE.
  - Latency from toggle detection to ep1tx=1 is REPORT_LEN+2 cycles.
- ep1tx stays 1 until the next IDLE decision. It is never set during FILL.
- Simultaneous toggle and req rising in the same cycle: the toggle is registered, then serviced in the next IDLE evaluation with the new req visible.
- Reset asserted mid-FILL: the fill is abandoned immediately, with no ack and ep1tx=0. The buffer content is undefined and is overwritten by the next fill.
- Widths: rd_addr and ep1wraddr count modulo 64. REPORT_LEN=64 must not wrap before COMMIT.

Test Plan:
- Reset, then hold req=00 and toggle ep1txd 3 times -> ep1tx stays 0; no ep1wr; ack=00; busy pulses never.
- Set req=01 with rd_data0 = 0x00,0x00,0x04,0,0,0,0,0 at addresses 0..7, then toggle -> gnt=01. Exactly 8 ep1wr pulses with addresses 0..7 and matching data; ep1tx=1 and ack=01 at 10 cycles after detection.
- ROUND_ROBIN=1 with req=11 held and 4 toggles -> grant order 0,1,0,1. Each ack is single-cycle and matches the granted source.
- ROUND_ROBIN=0 with req=11 and 3 toggles -> all grants to 0; requester 1 never acked.
- Toggle ep1txd twice during a fill -> one extra fill after COMMIT, not two; the second toggle is swallowed.
- Assert rst at write 4 of a fill -> all outputs return to reset values asynchronously with no ack. After release, req=10 plus a toggle gives a clean 8-byte fill from rd_data1.

Source files
------------

// File: rtl/ep1_report_arbiter_if.sv
// ep1_report_arbiter_if: report-source, read-port and EP1 buffer signals of the EP1 report arbiter.
interface ep1_report_arbiter_if;
   logic [1:0] req;
   logic [1:0] gnt;
   logic [1:0] ack;
   logic [5:0] rd_addr;
   logic [7:0] rd_data0;
   logic [7:0] rd_data1;
   logic       ep1txd;
   logic       ep1tx;
   logic [5:0] ep1wraddr;
   logic [7:0] ep1wrdata;
   logic       ep1wr;
   logic       busy;
   modport slave (
      input  req, rd_data0, rd_data1, ep1txd,
      output gnt, ack, rd_addr, ep1tx, ep1wraddr, ep1wrdata, ep1wr, busy
   );
   modport master (
      output req, rd_data0, rd_data1, ep1txd,
      input  gnt, ack, rd_addr, ep1tx, ep1wraddr, ep1wrdata, ep1wr, busy
   );
endinterface

// File: rtl/ep1_report_arbiter.sv
// ep1_report_arbiter: on each EP1 IN completion, copies one pending HID report into the EP1 buffer.
module ep1_report_arbiter #(
   parameter int REPORT_LEN  = 8,
   parameter bit ROUND_ROBIN = 1
) (
   input logic                 clk,
   input logic                 rst,
   ep1_report_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
   localparam logic [6:0] LAST = 7'(REPORT_LEN);
   state_t     r_state, w_state;
   logic [6:0] r_cnt, w_cnt;
   logic       r_win, w_win, r_last, w_last, r_tog, w_tog, r_tx, w_tx;
   logic       r_old, r_init;
   logic       w_edge, w_pick, w_wr;
   // r_init masks the first cycle after reset so the initial ep1txd level is not taken as a toggle
   assign w_edge = r_init && (bus.ep1txd != r_old);
   assign w_pick = (bus.req == 2'b10) || (bus.req == 2'b11 && ROUND_ROBIN && !r_last);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_win   <= 1'b0;
         r_last  <= 1'b1;
         r_tog   <= 1'b0;
         r_tx    <= 1'b0;
         r_old   <= 1'b0;
         r_init  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_win   <= w_win;
         r_last  <= w_last;
         r_tog   <= w_tog;
         r_tx    <= w_tx;
         r_old   <= bus.ep1txd;
         r_init  <= 1'b1;
      end
   end
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_win   = r_win;
      w_last  = r_last;
      w_tx    = r_tx;
      w_tog   = r_tog || w_edge;
      if (r_state == IDLE && r_tog) begin
         w_tog = w_edge;
         w_tx  = 1'b0;
         if (|bus.req) begin
            w_state = FILL;
            w_cnt   = '0;
            w_win   = w_pick;
            w_last  = w_pick;
         end
      end else if (r_state == FILL) begin
         w_cnt = r_cnt + 7'd1;
         if (r_cnt == LAST) begin
            w_state = COMMIT;
            w_tx    = 1'b1;
         end
      end else if (r_state == COMMIT) begin
         w_state = IDLE;
      end
   end
   // fill cycle k reads byte k; the write of byte k lands one cycle later, when the ROM data is valid
   assign w_wr          = (r_state == FILL) && (r_cnt != '0);
   assign bus.ep1wr     = w_wr;
   assign bus.ep1wraddr = w_wr ? 6'(r_cnt - 7'd1) : '0;
   assign bus.ep1wrdata = w_wr ? (r_win ? bus.rd_data1 : bus.rd_data0) : '0;
   assign bus.rd_addr   = (r_state == FILL && r_cnt != LAST) ? r_cnt[5:0] : '0;
   assign bus.gnt       = (r_state == FILL) ? {r_win, !r_win} : 2'b00;
   assign bus.ack       = (r_state == COMMIT) ? {r_win, !r_win} : 2'b00;
   assign bus.ep1tx     = r_tx;
   assign bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_ep1_report_arbiter.sv
// tb_ep1_report_arbiter: scoreboard bench driving a round-robin and a fixed-priority arbiter in lockstep.
module tb_ep1_report_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req = 2'b00;
   logic       ep1txd = 1'b0;
   logic [7:0] mem0 [64];
   logic [7:0] mem1 [64];
   logic [13:0] q_wr0 [$];
   logic [13:0] q_wr1 [$];
   logic [1:0]  q_ack0 [$];
   logic [1:0]  q_ack1 [$];
   logic [1:0]  prev_ack0 = 2'b00, prev_ack1 = 2'b00;
   logic        busy_seen = 1'b0;
   int n_tests = 0, n_fail = 0;
   ep1_report_arbiter_if bus0 ();
   ep1_report_arbiter_if bus1 ();
   ep1_report_arbiter #(.REPORT_LEN(8), .ROUND_ROBIN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   ep1_report_arbiter #(.REPORT_LEN(8), .ROUND_ROBIN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   always #5 clk = ~clk;
   assign bus0.req = req;
   assign bus1.req = req;
   assign bus0.ep1txd = ep1txd;
   assign bus1.ep1txd = ep1txd;
   // synchronous report ROMs, one cycle of read latency
   always @(posedge clk) begin
      bus0.rd_data0 <= mem0[bus0.rd_addr];
      bus0.rd_data1 <= mem1[bus0.rd_addr];
      bus1.rd_data0 <= mem0[bus1.rd_addr];
      bus1.rd_data1 <= mem1[bus1.rd_addr];
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask
   task automatic mon(input int i, input logic wr, input logic [13:0] w, input logic [1:0] ack,
                      input logic [1:0] gnt, input logic tx, input logic [1:0] prev);
      logic [13:0] e;
      logic [1:0]  ea;
      if (wr) begin
         if ((i == 0 ? q_wr0.size() : q_wr1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write dut%0d: got %h required none", i, w);
         end else begin
            if (i == 0) e = q_wr0.pop_front();
            else e = q_wr1.pop_front();
            chk($sformatf("write dut%0d", i), 32'(w), 32'(e));
         end
      end
      if (ack != 2'b00) begin
         if ((i == 0 ? q_ack0.size() : q_ack1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack dut%0d: got %b required none", i, ack);
         end else begin
            if (i == 0) ea = q_ack0.pop_front();
            else ea = q_ack1.pop_front();
            chk($sformatf("ack dut%0d", i), 32'(ack), 32'(ea));
            chk($sformatf("tx_at_ack dut%0d", i), 32'(tx), 1);
            chk($sformatf("gnt_at_ack dut%0d", i), 32'(gnt), 0);
         end
      end
      if (prev != 2'b00) chk($sformatf("ack_pulse dut%0d", i), 32'(ack), 0);
   endtask
   always @(negedge clk) begin
      if (bus0.busy || bus1.busy) busy_seen = 1'b1;
      mon(0, bus0.ep1wr, {bus0.ep1wraddr, bus0.ep1wrdata}, bus0.ack, bus0.gnt, bus0.ep1tx, prev_ack0);
      mon(1, bus1.ep1wr, {bus1.ep1wraddr, bus1.ep1wrdata}, bus1.ack, bus1.gnt, bus1.ep1tx, prev_ack1);
      prev_ack0 = bus0.ack;
      prev_ack1 = bus1.ack;
   end
   task automatic exp_fill(input logic w0, input logic w1);
      for (int a = 0; a < 8; a++) begin
         q_wr0.push_back({6'(a), w0 ? mem1[a] : mem0[a]});
         q_wr1.push_back({6'(a), w1 ? mem1[a] : mem0[a]});
      end
      q_ack0.push_back(w0 ? 2'b10 : 2'b01);
      q_ack1.push_back(w1 ? 2'b10 : 2'b01);
   endtask
   task automatic toggle();
      @(negedge clk);
      ep1txd = ~ep1txd;
   endtask
   // counts edges from the detection edge until ep1tx rises
   task automatic wait_tx(input logic [1:0] eg);
      int n;
      n = 0;
      @(posedge clk);
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) chk("gnt", 32'(bus0.gnt), 32'(eg));
      end while (!bus0.ep1tx && n < 100);
      chk("latency", n, 10);
      chk("tx dut1", 32'(bus1.ep1tx), 1);
   endtask
   task automatic chk_rst();
      chk("rst dut0", 32'({bus0.ep1tx, bus0.ep1wr, bus0.ep1wraddr, bus0.ep1wrdata, bus0.rd_addr,
                           bus0.gnt, bus0.ack, bus0.busy}), 0);
      chk("rst dut1", 32'({bus1.ep1tx, bus1.ep1wr, bus1.ep1wraddr, bus1.ep1wrdata, bus1.rd_addr,
                           bus1.gnt, bus1.ack, bus1.busy}), 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_rst();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   initial begin
      int k;
      for (int a = 0; a < 64; a++) begin
         mem0[a] = (a == 2) ? 8'h04 : 8'h00;
         mem1[a] = 8'hA0 + 8'(a);
      end
      repeat (3) @(posedge clk);
      #1;
      chk_rst();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      // no requester: toggles only re-arm the NAK
      repeat (3) begin
         toggle();
         repeat (5) @(negedge clk);
      end
      chk("busy_idle", 32'(busy_seen), 0);
      chk("tx_idle", 32'({bus0.ep1tx, bus1.ep1tx}), 0);
      @(negedge clk);
      req = 2'b01;
      exp_fill(1'b0, 1'b0);
      toggle();
      wait_tx(2'b01);
      @(negedge clk);
      req = 2'b00;
      do_reset();
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         exp_fill(1'(t % 2), 1'b0);
         toggle();
         wait_tx((t % 2) != 0 ? 2'b10 : 2'b01);
         repeat (2) @(negedge clk);
      end
      req = 2'b00;
      repeat (3) @(negedge clk);
      // two extra toggles during the fill collapse into one more fill
      req = 2'b01;
      exp_fill(1'b0, 1'b0);
      exp_fill(1'b0, 1'b0);
      toggle();
      repeat (3) @(negedge clk);
      toggle();
      repeat (2) @(negedge clk);
      toggle();
      repeat (40) @(negedge clk);
      req = 2'b00;
      chk("double_toggle_wr", q_wr0.size() + q_wr1.size(), 0);
      chk("double_toggle_ack", q_ack0.size() + q_ack1.size(), 0);
      repeat (3) @(negedge clk);
      req = 2'b01;
      exp_fill(1'b0, 1'b0);
      toggle();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(bus0.ep1wr && bus0.ep1wraddr == 6'd4) && k < 50);
      chk("write4_reached", 32'(bus0.ep1wraddr), 4);
      #2 rst = 1'b0;
      #1;
      chk_rst();
      q_wr0.delete();
      q_wr1.delete();
      q_ack0.delete();
      q_ack1.delete();
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      req = 2'b10;
      exp_fill(1'b1, 1'b1);
      toggle();
      wait_tx(2'b10);
      @(negedge clk);
      req = 2'b00;
      repeat (5) @(negedge clk);
      chk("final_wr_q", q_wr0.size() + q_wr1.size(), 0);
      chk("final_ack_q", q_ack0.size() + q_ack1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
